mmio_reg_bank_tri: RTL and testbench

//  Parametrised bank of NREGS memory-mapped registers on a shared tri-state read bus.

---
 rtl/mmio_reg_bank_tri_pkg.sv | 22 ++
 rtl/mmio_reg_bank_tri_cell.sv | 53 +++++
 rtl/mmio_reg_bank_tri.sv | 77 +++++++
 tb/tb_mmio_reg_bank_tri.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_reg_bank_tri_pkg.sv
// Shared definitions for the MMIO register bank: per-register access types
// and the helper that derives a register's access type from the bank masks.
package mmio_reg_bank_tri_pkg;

  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_RO  = 2'd1,
    ACC_W1C = 2'd2
  } acc_t;

  localparam int MAX_REGS = 16;

  // RO takes precedence if a caller ever sets both bits for one index.
  function automatic acc_t acc_of(input logic [MAX_REGS-1:0] ro_mask,
                                  input logic [MAX_REGS-1:0] w1c_mask,
                                  input int idx);
    if (ro_mask[idx])       return ACC_RO;
    else if (w1c_mask[idx]) return ACC_W1C;
    else                    return ACC_RW;
  endfunction

endpackage

// File: rtl/mmio_reg_bank_tri_cell.sv
// One WIDTH-bit register with byte-lane merge, W1C/RO behaviour and a
// one-cycle write pulse for accepted software writes.
module mmio_reg_cell
  import mmio_reg_bank_tri_pkg::*;
#(
  parameter int   WIDTH = 32,
  parameter acc_t ACC   = ACC_RW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   hw_in,
  input  logic [WIDTH-1:0]   hw_set,
  output logic [WIDTH-1:0]   q,
  output logic               wr_pulse
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] wmask, act_mask, rw_next, w1c_next;
  logic             pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{be[gi]}};
    end
  endgenerate

  assign act_mask = we ? wmask : '0;
  assign rw_next  = (q_reg & ~act_mask) | (wdata & act_mask);
  // Set is OR-ed after the clear so a simultaneous hw_set bit survives.
  assign w1c_next = (q_reg & ~(wdata & act_mask)) | hw_set;
  assign q_next   = (ACC == ACC_RO)  ? hw_in :
                    (ACC == ACC_W1C) ? w1c_next : rw_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_reg     <= '0;
      pulse_reg <= 1'b0;
    end else begin
      q_reg     <= q_next;
      pulse_reg <= we && (ACC != ACC_RO);
    end
  end

  assign q        = q_reg;
  assign wr_pulse = pulse_reg;

endmodule

// File: rtl/mmio_reg_bank_tri.sv
// Bank of NREGS MMIO registers: address decode, registered read buffer with
// a valid strobe, and a tri-state driver onto the shared read bus.
module mmio_reg_bank_tri
  import mmio_reg_bank_tri_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               NREGS    = 4,
  parameter int               ADDR_W   = 2,
  parameter logic [NREGS-1:0] RO_MASK  = '0,
  parameter logic [NREGS-1:0] W1C_MASK = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sel,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [WIDTH/8-1:0]     be,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rd_valid,
  input  logic [NREGS*WIDTH-1:0] hw_in,
  input  logic [NREGS*WIDTH-1:0] hw_set,
  output logic [NREGS*WIDTH-1:0] reg_q,
  output logic [NREGS-1:0]       wr_pulse
);

  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W + 1)'(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic             addr_ok, wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_buf_reg;
  logic             rd_valid_reg;

  assign addr_ok = {1'b0, addr} < NREGS_L;
  assign wr_acc  = sel && wr_en && addr_ok;
  // A combined write+read request performs only the write.
  assign rd_acc  = sel && rd_en && !wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      mmio_reg_cell #(
        .WIDTH (WIDTH),
        .ACC   (acc_of(MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK), gi))
      ) u_cell (
        .clock    (clock),
        .reset    (reset),
        .we       (wr_acc && (addr == ADDR_W'(gi))),
        .wdata    (wdata),
        .be       (be),
        .hw_in    (hw_in[gi*WIDTH +: WIDTH]),
        .hw_set   (hw_set[gi*WIDTH +: WIDTH]),
        .q        (regs[gi]),
        .wr_pulse (wr_pulse[gi])
      );
      assign reg_q[gi*WIDTH +: WIDTH] = regs[gi];
    end
  endgenerate

  assign rd_word = addr_ok ? regs[addr] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_buf_reg   <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (rd_acc) rd_buf_reg <= rd_word;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rdata    = rd_valid_reg ? rd_buf_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mmio_reg_bank_tri.sv
// Directed bench for mmio_reg_bank_tri: read results go through a scoreboard
// queue; register state, pulses and bus release are checked inline.
module tb_mmio_reg_bank_tri;

  localparam int WIDTH  = 32;
  localparam int NREGS  = 4;
  localparam int ADDR_W = 2;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   sel = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [ADDR_W-1:0]      addr = '0;
  logic [WIDTH-1:0]       wdata = '0;
  logic [WIDTH/8-1:0]     be = '0;
  wire  [WIDTH-1:0]       rdata;
  logic                   rd_valid;
  logic [NREGS*WIDTH-1:0] hw_in = '0;
  logic [NREGS*WIDTH-1:0] hw_set = '0;
  logic [NREGS*WIDTH-1:0] reg_q;
  logic [NREGS-1:0]       wr_pulse;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic [WIDTH-1:0] exp_q [$];

  mmio_reg_bank_tri #(
    .WIDTH    (WIDTH),
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .RO_MASK  (4'b0100),
    .W1C_MASK (4'b0010)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sel      (sel),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .hw_in    (hw_in),
    .hw_set   (hw_set),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endfunction

  function automatic void chk_z(input string name, input logic is_z, input logic vld);
    checks++;
    if (!is_z || vld !== 1'b0) begin
      errors++;
      $display("FAIL %s rdata_is_z=%0d rd_valid=%0d exp_z=1 exp_valid=0", name, is_z, vld);
    end
  endfunction

  function automatic logic [WIDTH-1:0] reg_of(input int i);
    return reg_q[i*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic s, input logic [ADDR_W-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [3:0] b);
    sel = s; wr_en = 1'b1; rd_en = 1'b0; addr = a; wdata = d; be = b;
    $display("WRITE sel=%0d addr=%0d data=%h be=%b", s, a, d, b);
    tick();
    sel = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp);
    sel = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = a;
    exp_q.push_back(exp);
    pushed++;
    $display("READ  addr=%0d expect=%h", a, exp);
    tick();
    sel = 1'b0; rd_en = 1'b0;
  endtask

  // Scoreboard monitor: one pop per cycle that the DUT presents a result.
  always @(negedge clock) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid got=%h exp=none", rdata);
      end else begin
        popped++;
        $display("RDATA got=%h", rdata);
        chk("read_data", rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    // 1: reset held for three cycles, then released
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("reset_reg_q0", reg_of(0), '0);
    chk("reset_reg_q3", reg_of(3), '0);
    chk("reset_rd_valid", {31'd0, rd_valid}, '0);
    chk_z("reset_rdata_z", rdata === {WIDTH{1'bz}}, rd_valid);
    reset = 1'b1;
    tick();
    chk("post_reset_reg_q", reg_q[63:0], '0);
    chk_z("post_reset_rdata_z", rdata === {WIDTH{1'bz}}, rd_valid);

    // 2: RW byte-lane write, pulse, read back
    do_write(1'b1, 2'd0, 32'hAABBCCDD, 4'b0101);
    chk("rw_byte_merge", reg_of(0), 32'h00BB00DD);
    chk("rw_pulse", {28'd0, wr_pulse}, 32'h1);
    tick();
    chk("rw_pulse_one_cycle", {28'd0, wr_pulse}, 32'h0);
    do_read(2'd0, 32'h00BB00DD);
    tick();

    // 3: W1C set, clear, set-wins, partial-lane clear
    hw_set[63:32] = 32'h5;
    tick();
    hw_set = '0;
    chk("w1c_set", reg_of(1), 32'h5);
    do_write(1'b1, 2'd1, 32'h1, 4'hF);
    chk("w1c_clear", reg_of(1), 32'h4);
    chk("w1c_pulse", {28'd0, wr_pulse}, 32'h2);
    hw_set[63:32] = 32'h1;
    do_write(1'b1, 2'd1, 32'h1, 4'hF);
    hw_set = '0;
    chk("w1c_set_wins", reg_of(1), 32'h5);
    do_write(1'b1, 2'd1, 32'h4, 4'b0001);
    chk("w1c_clear_bit2", reg_of(1), 32'h1);

    // 4: RO sampling and write ignore
    hw_in[95:64] = 32'h1234;
    tick();
    chk("ro_sample", reg_of(2), 32'h1234);
    do_write(1'b1, 2'd2, 32'hFFFF, 4'hF);
    chk("ro_write_ignored", reg_of(2), 32'h1234);
    chk("ro_no_pulse", {28'd0, wr_pulse}, 32'h0);
    hw_in[95:64] = 32'h5678;
    #1;
    chk("ro_latency_before", reg_of(2), 32'h1234);
    tick();
    chk("ro_latency_after", reg_of(2), 32'h5678);

    // 5: pipelined reads, write+read collision, deselected bus, edge cases
    sel = 1'b1; rd_en = 1'b1;
    addr = 2'd0; exp_q.push_back(32'h00BB00DD); pushed++; tick();
    addr = 2'd1; exp_q.push_back(32'h1);        pushed++; tick();
    addr = 2'd2; exp_q.push_back(32'h5678);     pushed++; tick();
    chk("pipelined_valid", {31'd0, rd_valid}, 32'h1);
    sel = 1'b0; rd_en = 1'b0;
    tick();

    sel = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 2'd3; wdata = 32'h11223344; be = 4'hF;
    tick();
    sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("wr_rd_no_valid", {31'd0, rd_valid}, 32'h0);
    chk("wr_rd_write_done", reg_of(3), 32'h11223344);
    chk("wr_rd_pulse", {28'd0, wr_pulse}, 32'h8);
    do_read(2'd3, 32'h11223344);

    do_write(1'b1, 2'd3, 32'hFFFFFFFF, 4'b0000);
    chk("be0_no_change", reg_of(3), 32'h11223344);
    chk("be0_pulse", {28'd0, wr_pulse}, 32'h8);
    do_write(1'b0, 2'd0, 32'h0, 4'hF);
    chk("unsel_write_ignored", reg_of(0), 32'h00BB00DD);
    chk("unsel_no_pulse", {28'd0, wr_pulse}, 32'h0);
    sel = 1'b0; rd_en = 1'b1; addr = 2'd0;
    tick();
    rd_en = 1'b0;
    chk_z("unsel_read_z", rdata === {WIDTH{1'bz}}, rd_valid);

    do_write(1'b1, 2'd0, 32'h12345678, 4'hF);
    do_read(2'd0, 32'h12345678);
    tick();

    // 6: reset asserted while a read result is on the bus
    sel = 1'b1; rd_en = 1'b1; addr = 2'd1;
    tick();
    sel = 1'b0; rd_en = 1'b0;
    chk("midread_valid_before", {31'd0, rd_valid}, 32'h1);
    reset = 1'b0;
    #1;
    chk_z("midread_reset_z", rdata === {WIDTH{1'bz}}, rd_valid);
    chk("midread_reg_clear", reg_of(1), '0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    chk("scoreboard_drained", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
